// File: rtl/auto_badpixel_list_writer.sv
`default_nettype none
// ============================================================================
// Module   : auto_badpixel_list_writer
// Purpose  : Collects detector-flagged bad-pixel coordinates for one frame,
//            stages them in a small FIFO and streams them into a coordinate
//            table, then commits the entry count when the frame completes.
// Revision : 1.0 - initial release
// ============================================================================
module auto_badpixel_list_writer #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 10,
  parameter int MAX_DP_NUM  = 128,
  parameter int MAX_DP_BIT  = 7,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   det_valid,
  input  logic [WIDTH_BITS-1:0]  det_x,
  input  logic [HEIGHT_BITS-1:0] det_y,
  input  logic                   wr_ready,
  output logic                   wen_lut,
  output logic [MAX_DP_BIT-1:0]  waddr_lut,
  output logic [31:0]            wdata_lut,
  output logic [MAX_DP_BIT-1:0]  bad_point_num,
  output logic                   list_done,
  output logic                   overflow,
  output logic                   busy
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_ENT_W = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [c_PTR_W:0]     c_FIFO_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [MAX_DP_BIT-1:0] c_CAP      = MAX_DP_BIT'(MAX_DP_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_fs_d;
  logic [c_ENT_W-1:0]      r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W:0]        r_cnt;
  logic [MAX_DP_BIT-1:0]   r_acc;
  logic                    r_last_vld;
  logic [WIDTH_BITS-1:0]   r_last_x;
  logic [HEIGHT_BITS-1:0]  r_last_y;
  logic [MAX_DP_BIT-1:0]   r_wptr;
  logic                    r_wen;
  logic [MAX_DP_BIT-1:0]   r_waddr;
  logic [31:0]             r_wdata;
  logic [MAX_DP_BIT-1:0]   r_bpn;
  logic                    r_list_done;
  logic                    r_overflow;

  logic                    w_fs_rise;
  logic                    w_collect;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_dup;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_pop;
  logic [c_ENT_W-1:0]      w_head;
  logic [WIDTH_BITS-1:0]   w_head_x;
  logic [HEIGHT_BITS-1:0]  w_head_y;

  assign w_fs_rise = frame_start & ~r_fs_d;
  assign w_collect = (r_state == S_COLLECT);
  assign w_full    = (r_cnt == c_FIFO_FULL);
  assign w_empty   = (r_cnt == '0);
  assign w_dup     = r_last_vld && (det_x == r_last_x) && (det_y == r_last_y);

  // The accepted count covers entries still waiting in the FIFO, so the table
  // can never be asked to hold more than c_CAP entries.
  assign w_push = w_collect & det_valid & ~w_dup & ~w_full & (r_acc < c_CAP) & ~w_fs_rise;
  assign w_drop = w_collect & det_valid & ~w_dup & ~w_push;
  assign w_pop  = (w_collect | (r_state == S_FLUSH)) & ~w_empty & wr_ready;

  assign w_head   = r_mem[r_rd_ptr];
  assign w_head_x = w_head[c_ENT_W-1:HEIGHT_BITS];
  assign w_head_y = w_head[HEIGHT_BITS-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {det_x, det_y};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fs_d      <= 1'b1;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_last_vld  <= 1'b0;
      r_last_x    <= '0;
      r_last_y    <= '0;
      r_wptr      <= '0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_bpn       <= '0;
      r_list_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_fs_d      <= frame_start;
      r_list_done <= 1'b0;
      r_wen       <= 1'b0;

      if (w_fs_rise) begin
        // A new frame pre-empts whatever was in progress, including a
        // simultaneous frame_end and any write still queued.
        r_state    <= S_COLLECT;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_cnt      <= '0;
        r_acc      <= '0;
        r_last_vld <= 1'b0;
        r_last_x   <= '0;
        r_last_y   <= '0;
        r_wptr     <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + 1'b1;
          r_acc      <= r_acc + 1'b1;
          r_last_vld <= 1'b1;
          r_last_x   <= det_x;
          r_last_y   <= det_y;
        end

        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_wen    <= 1'b1;
          r_waddr  <= r_wptr;
          r_wdata  <= {16'(w_head_x), 16'(w_head_y)};
          r_wptr   <= r_wptr + 1'b1;
        end

        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: ;
        endcase

        if (w_drop) begin
          r_overflow <= 1'b1;
        end

        case (r_state)
          S_COLLECT: begin
            if (frame_end) begin
              r_state <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            if (w_empty && !r_wen) begin
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            r_bpn       <= r_wptr;
            r_list_done <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign wen_lut       = r_wen;
  assign waddr_lut     = r_waddr;
  assign wdata_lut     = r_wdata;
  assign bad_point_num = r_bpn;
  assign list_done     = r_list_done;
  assign overflow      = r_overflow;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_auto_badpixel_list_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_auto_badpixel_list_writer
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized frames against a list-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_auto_badpixel_list_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        frame_end;
  logic        det_valid;
  logic [9:0]  det_x;
  logic [9:0]  det_y;
  logic        wr_ready;
  logic        wen_lut;
  logic [6:0]  waddr_lut;
  logic [31:0] wdata_lut;
  logic [6:0]  bad_point_num;
  logic        list_done;
  logic        overflow;
  logic        busy;

  auto_badpixel_list_writer dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .det_valid     (det_valid),
    .det_x         (det_x),
    .det_y         (det_y),
    .wr_ready      (wr_ready),
    .wen_lut       (wen_lut),
    .waddr_lut     (waddr_lut),
    .wdata_lut     (wdata_lut),
    .bad_point_num (bad_point_num),
    .list_done     (list_done),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  logic [6:0]  cap_addr[$];
  logic [31:0] cap_data[$];

  bit          stim_v[$];
  logic [9:0]  stim_x[$];
  logic [9:0]  stim_y[$];
  logic [31:0] exp_d[$];
  logic        exp_ovf;
  int          last_bpn = 0;

  typedef struct {
    int               n_det;
    logic [3:0][9:0]  xs;
    logic [3:0][9:0]  ys;
    int               exp_num;
    logic [3:0][31:0] exp_data;
  } vec_t;
  vec_t vecs[4];

  always @(negedge clk) begin
    if (wen_lut) begin
      cap_addr.push_back(waddr_lut);
      cap_data.push_back(wdata_lut);
    end
    if (list_done) n_done++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] pack(input logic [9:0] x, input logic [9:0] y);
    return {6'd0, x, 6'd0, y};
  endfunction

  // Reference: a detection joins the list unless it repeats the last listed
  // entry; once the list holds 127 entries every other detection is lost.
  task automatic build_expect();
    logic [31:0] d;
    logic [31:0] last = '0;
    bit          have_last = 0;
    exp_d.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < stim_v.size(); i++) begin
      if (stim_v[i]) begin
        d = pack(stim_x[i], stim_y[i]);
        if (!(have_last && d == last)) begin
          if (exp_d.size() < 127) begin
            exp_d.push_back(d);
            last = d;
            have_last = 1;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    frame_start = 1'b0;
    cap_addr.delete();
    cap_data.delete();
    n_done = 0;
    @(posedge clk); #1;
    frame_start = 1'b1;
  endtask

  task automatic drive_dets();
    for (int i = 0; i < stim_v.size(); i++) begin
      @(posedge clk); #1;
      det_valid = stim_v[i];
      det_x     = stim_x[i];
      det_y     = stim_y[i];
    end
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    det_valid = 1'b0;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && n_done == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_nwr"}, cap_data.size(), exp_d.size());
    for (int k = 0; k < cap_data.size() && k < exp_d.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), cap_addr[k], k);
      chk($sformatf("%s_data%0d", tag, k), cap_data[k], exp_d[k]);
    end
    chk({tag, "_bpn"}, bad_point_num, exp_d.size());
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_busy"}, busy, 0);
    last_bpn = exp_d.size();
  endtask

  task automatic clear_stim();
    stim_v.delete();
    stim_x.delete();
    stim_y.delete();
  endtask

  task automatic add_det(input logic [9:0] x, input logic [9:0] y);
    stim_v.push_back(1'b1);
    stim_x.push_back(x);
    stim_y.push_back(y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].n_det = 3; vecs[0].exp_num = 3;
    vecs[0].xs = {10'd0, 10'd3, 10'd9, 10'd5};
    vecs[0].ys = {10'd0, 10'd7, 10'd2, 10'd2};
    vecs[0].exp_data = {32'h0, 32'h00030007, 32'h00090002, 32'h00050002};
    vecs[1].n_det = 3; vecs[1].exp_num = 1;
    vecs[1].xs = {10'd0, 10'd4, 10'd4, 10'd4};
    vecs[1].ys = {10'd0, 10'd4, 10'd4, 10'd4};
    vecs[1].exp_data = {32'h0, 32'h0, 32'h0, 32'h00040004};
    vecs[2].n_det = 4; vecs[2].exp_num = 3;
    vecs[2].xs = {10'd1, 10'd1, 10'd2, 10'd1};
    vecs[2].ys = {10'd1, 10'd1, 10'd2, 10'd1};
    vecs[2].exp_data = {32'h0, 32'h00010001, 32'h00020002, 32'h00010001};
    vecs[3].n_det = 2; vecs[3].exp_num = 2;
    vecs[3].xs = {10'd0, 10'd0, 10'd1023, 10'd0};
    vecs[3].ys = {10'd0, 10'd0, 10'd1023, 10'd0};
    vecs[3].exp_data = {32'h0, 32'h0, 32'h03FF03FF, 32'h00000000};

    rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; det_valid = 1'b0;
    det_x = '0; det_y = '0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wen", wen_lut, 0);
    chk("rst_waddr", waddr_lut, 0);
    chk("rst_wdata", wdata_lut, 0);
    chk("rst_bpn", bad_point_num, 0);
    chk("rst_done", list_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);

    // Latency: accept at edge N, table write visible after edge N+1.
    start_frame();
    @(posedge clk); #1;
    det_valid = 1'b1; det_x = 10'd11; det_y = 10'd12;
    @(posedge clk); #1;
    det_valid = 1'b0;
    @(negedge clk); chk("lat_wen_n", wen_lut, 0);
    @(negedge clk); chk("lat_wen_n1", wen_lut, 1);
    chk("lat_addr", waddr_lut, 0);
    chk("lat_data", wdata_lut, 32'h000B000C);
    @(negedge clk); chk("lat_wen_n2", wen_lut, 0);
    chk("lat_busy", busy, 1);
    end_frame();
    wait_done();
    exp_d.delete(); exp_d.push_back(32'h000B000C); exp_ovf = 1'b0;
    check_result("lat");

    for (int v = 0; v < 4; v++) begin
      clear_stim();
      for (int j = 0; j < vecs[v].n_det; j++) add_det(vecs[v].xs[j], vecs[v].ys[j]);
      exp_d.delete();
      for (int j = 0; j < vecs[v].exp_num; j++) exp_d.push_back(vecs[v].exp_data[j]);
      exp_ovf = 1'b0;
      start_frame();
      drive_dets();
      end_frame();
      wait_done();
      check_result($sformatf("vec%0d", v));
    end

    // Stalled table port: only the FIFO depth can be absorbed.
    wr_ready = 1'b0;
    clear_stim();
    for (int j = 0; j < 6; j++) add_det(10'(20 + j), 10'(j));
    start_frame();
    drive_dets();
    @(posedge clk); #1 det_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stall_ovf_mid", overflow, 1);
    chk("stall_nwr_mid", cap_data.size(), 0);
    wr_ready = 1'b1;
    end_frame();
    wait_done();
    exp_d.delete();
    for (int j = 0; j < 4; j++) exp_d.push_back(pack(10'(20 + j), 10'(j)));
    exp_ovf = 1'b1;
    check_result("stall");

    // Capacity: 130 distinct detections.
    clear_stim();
    for (int j = 0; j < 130; j++) add_det(10'(j), 10'((j * 7) % 1024));
    build_expect();
    start_frame();
    drive_dets();
    end_frame();
    wait_done();
    check_result("cap");

    for (int f = 0; f < 6; f++) begin
      int n;
      clear_stim();
      n = $urandom_range(10, 60);
      for (int j = 0; j < n; j++) begin
        stim_v.push_back($urandom_range(0, 3) != 0);
        stim_x.push_back(10'($urandom_range(0, 3)));
        stim_y.push_back(10'($urandom_range(0, 2)));
      end
      build_expect();
      start_frame();
      drive_dets();
      end_frame();
      wait_done();
      check_result($sformatf("rnd%0d", f));
    end

    // frame_start re-rises while FLUSH still holds two entries.
    begin
      int prev_bpn;
      prev_bpn = last_bpn;
      wr_ready = 1'b0;
      clear_stim();
      add_det(10'd8, 10'd1);
      add_det(10'd8, 10'd2);
      start_frame();
      drive_dets();
      end_frame();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("restart_busy_flush", busy, 1);
      #4 frame_start = 1'b0;
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 wr_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("restart_nwr", cap_data.size(), 0);
      chk("restart_done", n_done, 0);
      chk("restart_bpn", bad_point_num, prev_bpn);
      chk("restart_busy", busy, 1);
      clear_stim();
      add_det(10'd7, 10'd7);
      drive_dets();
      end_frame();
      wait_done();
      exp_d.delete(); exp_d.push_back(32'h00070007); exp_ovf = 1'b0;
      check_result("restart");
    end

    // frame_start rising together with frame_end: new frame wins.
    clear_stim();
    add_det(10'd2, 10'd3);
    start_frame();
    drive_dets();
    @(posedge clk); #1 det_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1 frame_start = 1'b1; frame_end = 1'b1;
    @(posedge clk); #1 frame_end = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("tie_done", n_done, 0);
    chk("tie_busy", busy, 1);
    cap_addr.delete();
    cap_data.delete();
    clear_stim();
    add_det(10'd6, 10'd6);
    drive_dets();
    end_frame();
    wait_done();
    exp_d.delete(); exp_d.push_back(32'h00060006); exp_ovf = 1'b0;
    check_result("tie");

    // Reset mid-frame with frame_start held high.
    clear_stim();
    for (int j = 0; j < 4; j++) add_det(10'(40 + j), 10'd9);
    start_frame();
    @(posedge clk); #1 det_valid = 1'b1; det_x = 10'd40; det_y = 10'd9;
    @(posedge clk); #1 det_x = 10'd41;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cap_addr.delete();
    cap_data.delete();
    n_done = 0;
    @(negedge clk);
    chk("mrst_wen", wen_lut, 0);
    chk("mrst_wdata", wdata_lut, 0);
    chk("mrst_bpn", bad_point_num, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_busy", busy, 0);
    #4 det_x = 10'd50; frame_end = 1'b1;
    @(posedge clk); #1 frame_end = 1'b0;
    repeat (5) @(posedge clk);
    #1 det_valid = 1'b0;
    @(negedge clk);
    chk("mrst_busy_held", busy, 0);
    chk("mrst_nwr", cap_data.size(), 0);
    chk("mrst_done", n_done, 0);
    clear_stim();
    add_det(10'd1, 10'd2);
    start_frame();
    drive_dets();
    end_frame();
    wait_done();
    exp_d.delete(); exp_d.push_back(32'h00010002); exp_ovf = 1'b0;
    check_result("mrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/auto_badpixel_list_writer.md
AUTO_BADPIXEL_LIST_WRITER -- requirements
Module: auto_badpixel_list_writer

Interface
REQ-001 The block SHALL have parameters: WIDTH_BITS, default 10, x coordinate width; HEIGHT_BITS, default 10, y coordinate width; MAX_DP_NUM, default 128, table depth; MAX_DP_BIT, default 7, table address/count width; FIFO_DEPTH, default 4, staging FIFO entries (power of 2).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  clock for all logic.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 frame_start  input  1  level; its rising edge starts a frame.
REQ-006 frame_end  input  1  one-cycle pulse marking the end of pixel scan.
REQ-007 det_valid  input  1  detector flags the current pixel as bad.
REQ-008 det_x  input  WIDTH_BITS  x of flagged pixel.
REQ-009 det_y  input  HEIGHT_BITS  y of flagged pixel.
REQ-010 wr_ready  input  1  table write port is available this cycle.
REQ-011 wen_lut  output  1  table write enable, one cycle per entry.
REQ-012 waddr_lut  output  MAX_DP_BIT  table write address.
REQ-013 wdata_lut  output  32  entry: [31:16] x zero-extended, [15:0] y zero-extended.
REQ-014 bad_point_num  output  MAX_DP_BIT  committed entry count of the last completed frame.
REQ-015 list_done  output  1  one-cycle pulse when bad_point_num is committed.
REQ-016 overflow  output  1  sticky per frame; a detection was dropped for lack of space.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, COLLECT, FLUSH and DONE.
REQ-019 A rising edge of frame_start, detected against a registered copy, SHALL move any state to COLLECT, clear wptr, the FIFO, overflow and the last-entry register, and cancel any pending write.
REQ-020 Capacity SHALL be MAX_DP_NUM-1 entries, so that the count fits in MAX_DP_BIT bits.
REQ-021 In COLLECT, det_valid SHALL be accepted when the FIFO is not full and accepted-count < capacity; the accepted-count includes entries still in the FIFO.
REQ-022 det_valid whose (x,y) equals the last accepted entry of this frame SHALL be dropped silently, with no overflow.
REQ-023 Any other det_valid that is not accepted (FIFO full or capacity reached) SHALL set overflow.
REQ-024 det_valid outside COLLECT SHALL be ignored.
REQ-025 In COLLECT or FLUSH, when the FIFO is non-empty and wr_ready=1, the head SHALL be popped at that edge; wen_lut=1 with waddr_lut=wptr and wdata_lut=head SHALL follow in the next cycle, then wptr increments.
REQ-026 wen_lut, waddr_lut and wdata_lut SHALL be registered; wen_lut SHALL never be high on two entries with the same address within one frame.
REQ-027 Latency SHALL be: detection accepted at edge N, wen_lut high in cycle N+2 when wr_ready=1 at N+1.
REQ-028 frame_end in COLLECT SHALL cause a transition to FLUSH; det_valid in the same cycle SHALL still be accepted.
REQ-029 FLUSH SHALL transition to DONE when the FIFO is empty and no write is in flight.
REQ-030 In DONE, the block SHALL set bad_point_num<=wptr, pulse list_done for exactly one cycle, and return to IDLE next.
REQ-031 bad_point_num SHALL hold its prior value until the DONE commit.
REQ-032 When frame_start rises in the same cycle as frame_end, frame_start SHALL win: no list_done is issued and the new frame begins.
REQ-033 frame_end in IDLE, FLUSH or DONE SHALL be ignored.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL set state IDLE, all outputs 0, FIFO empty, wptr 0, and the frame_start history register to 1, so a frame_start held high through reset does not start a frame.
REQ-035 Reset SHALL override all other inputs, including in mid-frame and mid-write, and SHALL issue no list_done.

Verification
REQ-036 Three detections (5,2),(9,2),(3,7) with wr_ready=1, then frame_end -> writes to addr 0,1,2 with data 0x00050002, 0x00090002, 0x00030007; list_done pulses once; bad_point_num=3; overflow=0.
REQ-037 det_valid for (4,4) held 3 consecutive cycles -> one write only; bad_point_num=1; overflow=0.
REQ-038 wr_ready=0 while 6 distinct detections arrive (FIFO_DEPTH=4) -> 4 stored, overflow=1; after wr_ready=1 and frame_end, bad_point_num=4.
REQ-039 130 distinct detections at MAX_DP_NUM=128 with wr_ready=1 -> 127 writes, addr 0..126; overflow=1; bad_point_num=127.
REQ-040 frame_start re-rises during FLUSH with 2 entries pending -> pending writes dropped; no list_done; bad_point_num unchanged; wptr restarts at 0.
REQ-041 rst asserted mid-COLLECT with frame_start held high, then released -> all outputs 0; no frame starts until frame_start falls and rises again.
